// File: rtl/lem_vram_loader.sv
// lem_vram_loader: copies a WORDS-word cell block from DCPU memory into the screen VRAM.
// Optional frame-tick refresh copies are enabled by defining LEM_VRAM_LOADER_REFRESH_EN.
module lem_vram_loader #(
  parameter int WORDS = 384,
  parameter int VRAM_AW = 9,
  parameter int RD_LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [15:0]        cmd_base,
  output logic               bus_req,
  input  logic               bus_gnt,
  output logic               bus_rd,
  output logic [15:0]        bus_addr,
  input  logic [15:0]        bus_rd_data,
  output logic               vram_wren,
  output logic [VRAM_AW-1:0] vram_wraddr,
  output logic [15:0]        vram_wrdata,
  output logic               mapped,
  output logic               busy,
  output logic               done,
  input  logic               frame_tick
);
  typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, DONE} state_t;
  state_t state;
  logic [15:0] base;
  logic [8:0] issue_cnt, ret_cnt;
  logic [RD_LAT-1:0] pipe_v;
  logic [VRAM_AW-1:0] pipe_i [RD_LAT];
  logic last_ret, refresh;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign bus_req = state == REQ || state == XFER;
  // Read strobe is combinational so it can never outlive a dropped grant.
  assign bus_rd = state == XFER && bus_gnt && issue_cnt < 9'(WORDS);
  assign bus_addr = base + {7'd0, issue_cnt};
  assign vram_wren = pipe_v[RD_LAT-1];
  assign vram_wraddr = pipe_i[RD_LAT-1];
  assign vram_wrdata = vram_wren ? bus_rd_data : '0;
  assign last_ret = vram_wren && ret_cnt == 9'(WORDS - 1);
`ifdef LEM_VRAM_LOADER_REFRESH_EN
  logic pend;
  assign refresh = mapped && (frame_tick || pend);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      pend <= 1'b0;
    else if (state == IDLE && cmd_valid)
      pend <= 1'b0;
    else if (refresh && (state == IDLE || state == DONE))
      pend <= 1'b0;
    else if (frame_tick && state != IDLE)
      pend <= 1'b1;
  end
`else
  logic unused_tick;
  assign unused_tick = frame_tick;
  assign refresh = 1'b0;
`endif
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      base <= '0;
      issue_cnt <= '0;
      ret_cnt <= '0;
      mapped <= 1'b0;
      done <= 1'b0;
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_i[i] <= '0;
    end else begin
      done <= 1'b0;
      pipe_v[0] <= bus_rd;
      pipe_i[0] <= VRAM_AW'(issue_cnt);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_i[i] <= pipe_i[i-1];
      end
      if (vram_wren) ret_cnt <= ret_cnt + 9'd1;
      case (state)
        IDLE:
          if (cmd_valid) begin
            base <= cmd_base;
            mapped <= cmd_base != 16'd0;
            if (cmd_base == 16'd0) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              issue_cnt <= '0;
              ret_cnt <= '0;
              state <= REQ;
            end
          end else if (refresh) begin
            issue_cnt <= '0;
            ret_cnt <= '0;
            state <= REQ;
          end
        REQ: if (bus_gnt) state <= XFER;
        XFER:
          if (bus_rd) begin
            issue_cnt <= issue_cnt + 9'd1;
            if (issue_cnt == 9'(WORDS - 1)) state <= DRAIN;
          end
        // Leave on the cycle the final write lands so done follows it directly.
        DRAIN:
          if (last_ret) begin
            state <= DONE;
            done <= 1'b1;
          end
        DONE:
          if (refresh) begin
            issue_cnt <= '0;
            ret_cnt <= '0;
            state <= REQ;
          end else
            state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lem_vram_loader.sv
// tb_lem_vram_loader: directed self-checking bench for lem_vram_loader.
module tb_lem_vram_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, bus_gnt = 1'b1, frame_tick = 1'b0;
  logic [15:0] cmd_base = 16'd0;
  logic cmd_ready, bus_req, bus_rd, vram_wren, mapped, busy, done;
  logic [15:0] bus_addr, bus_rd_data, vram_wrdata;
  logic [8:0] vram_wraddr;
  logic [15:0] ma0 = 16'd0, ma1 = 16'd0;
  logic [15:0] exp_base = 16'd0;
  logic [15:0] seen [512];
  int checks = 0, failures = 0;
  int wr_cnt = 0, wr_err = 0, bad_rd = 0, req_cycles = 0, done_cnt = 0;

  lem_vram_loader dut (
    .CLK(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_rd(bus_rd), .bus_addr(bus_addr),
    .bus_rd_data(bus_rd_data), .vram_wren(vram_wren), .vram_wraddr(vram_wraddr),
    .vram_wrdata(vram_wrdata), .mapped(mapped), .busy(busy), .done(done), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Memory returns addr ^ 0xA5A5 two cycles after the read strobe.
  always @(posedge clk) begin
    ma0 <= bus_addr;
    ma1 <= ma0;
  end
  assign bus_rd_data = ma1 ^ 16'hA5A5;

  always @(posedge clk) begin
    if (vram_wren) begin
      if (vram_wraddr !== wr_cnt[8:0] || vram_wrdata !== ((exp_base + 16'(wr_cnt)) ^ 16'hA5A5))
        wr_err++;
      seen[vram_wraddr] = vram_wrdata;
      wr_cnt++;
    end
    if (bus_rd && !bus_gnt) bad_rd++;
    if (bus_req) req_cycles++;
    if (done) done_cnt++;
  end

  task automatic clr_mon();
    wr_cnt = 0; wr_err = 0; bad_rd = 0; req_cycles = 0; done_cnt = 0;
  endtask

  // Issue a command in the current cycle; k_done is the cycle offset of done, -1 on timeout.
  task automatic run_cmd(input logic [15:0] b, input bit toggle, output int k_done);
    exp_base = b;
    cmd_base = b;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k_done = -1;
    for (int k = 1; k <= 3000; k++) begin
      if (toggle) bus_gnt = ~bus_gnt;
      if (done) begin
        k_done = k;
        break;
      end
      @(posedge clk); #1;
    end
    bus_gnt = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({bus_req, bus_rd, vram_wren, mapped, busy, done} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {bus_req, bus_rd, vram_wren, mapped, busy, done}); end
    checks++; if (bus_addr !== 16'd0 || vram_wraddr !== 9'd0 || vram_wrdata !== 16'd0) begin failures++; $display("FAIL reset_buses got=%h/%h/%h exp=0", bus_addr, vram_wraddr, vram_wrdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_copy();
    int k;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL copy_ready got=%b exp=1", cmd_ready); end
    clr_mon();
    run_cmd(16'h8000, 1'b0, k);
    checks++; if (k !== 388) begin failures++; $display("FAIL copy_done_latency got=%0d exp=388", k); end
    checks++; if (wr_cnt !== 384) begin failures++; $display("FAIL copy_writes got=%0d exp=384", wr_cnt); end
    checks++; if (wr_err !== 0) begin failures++; $display("FAIL copy_write_data got=%0d bad exp=0", wr_err); end
    checks++; if (mapped !== 1'b1) begin failures++; $display("FAIL copy_mapped got=%b exp=1", mapped); end
    checks++; if (req_cycles !== 385) begin failures++; $display("FAIL copy_req_cycles got=%0d exp=385", req_cycles); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL copy_after_done got=%b%b%b exp=001", done, busy, cmd_ready); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL copy_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_wrap();
    int k;
    clr_mon();
    run_cmd(16'hFF00, 1'b0, k);
    checks++; if (seen[255] !== 16'h5A5A) begin failures++; $display("FAIL wrap_idx255 got=%h exp=5a5a", seen[255]); end
    checks++; if (seen[256] !== 16'hA5A5) begin failures++; $display("FAIL wrap_idx256 got=%h exp=a5a5", seen[256]); end
    checks++; if (wr_err !== 0 || wr_cnt !== 384) begin failures++; $display("FAIL wrap_stream got=%0d bad %0d writes exp=0 bad 384 writes", wr_err, wr_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_gnt_toggle();
    int k;
    clr_mon();
    run_cmd(16'h4321, 1'b1, k);
    checks++; if (k < 0) begin failures++; $display("FAIL toggle_done got=timeout exp=done"); end
    checks++; if (bad_rd !== 0) begin failures++; $display("FAIL toggle_rd_no_gnt got=%0d exp=0", bad_rd); end
    checks++; if (wr_cnt !== 384 || wr_err !== 0) begin failures++; $display("FAIL toggle_writes got=%0d writes %0d bad exp=384 writes 0 bad", wr_cnt, wr_err); end
    checks++; if (req_cycles <= 385) begin failures++; $display("FAIL toggle_req_cycles got=%0d exp=>385", req_cycles); end
    @(posedge clk); #1;
  endtask

  task automatic test_disconnect();
    int k;
    clr_mon();
    run_cmd(16'h0000, 1'b0, k);
    checks++; if (k !== 1) begin failures++; $display("FAIL disc_done_latency got=%0d exp=1", k); end
    checks++; if (req_cycles !== 0 || wr_cnt !== 0) begin failures++; $display("FAIL disc_activity got=%0d req %0d writes exp=0", req_cycles, wr_cnt); end
    checks++; if (mapped !== 1'b0) begin failures++; $display("FAIL disc_mapped got=%b exp=0", mapped); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_copy();
    int k;
    clr_mon();
    exp_base = 16'h8000;
    cmd_base = 16'h8000;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 1000 && wr_cnt < 100; c++) begin
      @(posedge clk); #1;
    end
    checks++; if (wr_cnt !== 100) begin failures++; $display("FAIL midrst_reach100 got=%0d exp=100", wr_cnt); end
    rst = 1'b1;
    #1;
    checks++; if ({bus_req, bus_rd, vram_wren, mapped, busy, done} !== 6'b0) begin failures++; $display("FAIL midrst_flags got=%b exp=000000", {bus_req, bus_rd, vram_wren, mapped, busy, done}); end
    checks++; if (bus_addr !== 16'd0 || vram_wraddr !== 9'd0 || vram_wrdata !== 16'd0) begin failures++; $display("FAIL midrst_buses got=%h/%h/%h exp=0", bus_addr, vram_wraddr, vram_wrdata); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", cmd_ready); end
    checks++; if (wr_cnt !== 100) begin failures++; $display("FAIL midrst_no_more_writes got=%0d exp=100", wr_cnt); end
    clr_mon();
    run_cmd(16'h0123, 1'b0, k);
    checks++; if (k !== 388 || wr_cnt !== 384 || wr_err !== 0) begin failures++; $display("FAIL midrst_fresh got=%0d/%0d/%0d exp=388/384/0", k, wr_cnt, wr_err); end
    @(posedge clk); #1;
  endtask

`ifdef LEM_VRAM_LOADER_REFRESH_EN
  task automatic test_refresh();
    int k = -1;
    clr_mon();
    exp_base = 16'h8000;
    cmd_base = 16'h8000;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      frame_tick = (c == 10 || c == 20);
      if (done) begin
        k = c;
        break;
      end
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
    checks++; if (k !== 388) begin failures++; $display("FAIL refresh_first_done got=%0d exp=388", k); end
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL refresh_restart got=%b exp=1", bus_req); end
    wr_cnt = 0;
    k = -1;
    for (int c = 1; c <= 1000; c++) begin
      if (done) begin
        k = c;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (k !== 388 || wr_cnt !== 384 || wr_err !== 0) begin failures++; $display("FAIL refresh_second_copy got=%0d/%0d/%0d exp=388/384/0", k, wr_cnt, wr_err); end
    req_cycles = 0;
    repeat (50) @(posedge clk);
    #1;
    checks++; if (req_cycles !== 0 || done_cnt !== 2) begin failures++; $display("FAIL refresh_single_extra got=%0d req %0d done exp=0 req 2 done", req_cycles, done_cnt); end
  endtask
`else
  task automatic test_refresh();
    checks++; if (mapped !== 1'b1) begin failures++; $display("FAIL norefresh_mapped got=%b exp=1", mapped); end
    req_cycles = 0;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (req_cycles !== 0 || busy !== 1'b0) begin failures++; $display("FAIL norefresh_idle got=%0d req busy=%b exp=0 req busy=0", req_cycles, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_copy();
    test_wrap();
    test_gnt_toggle();
    test_disconnect();
    test_reset_mid_copy();
    test_refresh();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lem_vram_loader.md
Name: lem_vram_loader

Overview:
- Upstream feeder for the screen controller's VRAM.
- On a MEM_MAP_SCREEN-style command from the DCPU hardware interface, it arbitrates for the DCPU main-memory bus.
- It then copies a 384-word cell block starting at a DCPU base address into the 9-bit-addressed VRAM write port. The screen controller reads that VRAM on its own read clock.

Parameters:
- WORDS, 384, words per copy; equals the number of 32x12 screen cells.
- VRAM_AW, 9, VRAM write-address width.
- RD_LAT, 2, fixed main-memory read latency in cycles (bus_rd to bus_rd_data valid); must be 1..4.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  copy/map command strobe.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_base  in  16  DCPU base address; 0 means disconnect.
- bus_req  out  1  main-memory bus request to the arbiter.
- bus_gnt  in  1  arbiter grant; may drop on any cycle.
- bus_rd  out  1  read strobe; only asserted while bus_gnt=1.
- bus_addr  out  16  read address.
- bus_rd_data  in  16  read data, valid RD_LAT cycles after bus_rd.
- vram_wren  out  1  VRAM write enable.
- vram_wraddr  out  VRAM_AW  VRAM word address.
- vram_wrdata  out  16  VRAM write data.
- mapped  out  1  screen is currently mapped (last base was non-zero).
- busy  out  1  copy in progress (state is not IDLE).
- done  out  1  one-cycle completion pulse.
- frame_tick  in  1  vertical-sync pulse from the screen controller (used only with the optional feature).

Behaviour:
- Reset values: bus_req, bus_rd, vram_wren, mapped, busy and done are 0. bus_addr, vram_wraddr and vram_wrdata are 0. State is IDLE, so cmd_ready=1.
- Reset asserted mid-copy aborts immediately. Pending return-pipeline entries are cleared and no further VRAM writes occur.
- States and transitions:
  - IDLE: cmd_ready=1. When cmd_valid=1, latch cmd_base.
    - If the base is 0: set mapped=0 and go to DONE. No bus activity occurs.
    - Otherwise: set mapped=1, clear issue_cnt and ret_cnt, and go to REQ.
  - REQ: bus_req=1. When bus_gnt=1, go to XFER.
  - XFER: bus_req=1. On each cycle with bus_gnt=1 and issue_cnt<WORDS:
    - bus_rd=1 and bus_addr=(base+issue_cnt) mod 2^16. The address wraps from 0xFFFF to 0x0000.
    - issue_cnt increments.
    - On the cycle issue_cnt reaches WORDS, go to DRAIN.
  - Grant loss in XFER: no bus_rd that cycle and no issue; bus_req stays high.
  - DRAIN: bus_req=0. Wait until ret_cnt==WORDS, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Return pipeline:
  - An RD_LAT-deep shift register carries a valid bit and the VRAM index of each issued read.
  - When an entry exits: vram_wren=1, vram_wraddr=index, vram_wrdata=bus_rd_data, and ret_cnt increments.
  - Writes occur in ascending index order, exactly once per index from 0 to WORDS-1.
- Latency: with grant held continuously, the first VRAM write occurs RD_LAT cycles after the first bus_rd. done occurs WORDS+RD_LAT+2 cycles after the command is accepted.
- Ignored inputs:
  - cmd_valid outside IDLE is ignored (cmd_ready=0). The command is not queued.
  - bus_gnt outside REQ/XFER is ignored.
- Counters: issue_cnt and ret_cnt are 9 bits wide and never exceed WORDS.

Optional Feature:
- Macro: LEM_VRAM_LOADER_REFRESH_EN.
- Enabled:
  - When mapped=1 and a frame_tick occurs in IDLE, start a copy from the latched base, exactly as for a command.
  - A frame_tick while busy sets a single pending flag. Additional ticks do not accumulate.
  - When in IDLE with the pending flag set, a new copy starts (REQ) on the cycle after DONE.
  - If cmd_valid and a refresh trigger occur in the same IDLE cycle, the command wins and clears the pending flag.
  - A base-0 command clears the pending flag.
- Disabled: frame_tick is ignored and the pending logic is absent.

Test Plan:
1. bus_gnt tied to 1, RD_LAT=2, memory model returns addr^0xA5A5, command with base 0x8000 -> exactly 384 writes, vram_wraddr 0..383, data (0x8000+i)^0xA5A5; done exactly 388 cycles after the command is accepted; mapped=1.
2. Base 0xFF00 -> VRAM index 255 receives mem[0xFFFF]^0xA5A5 and index 256 receives mem[0x0000]^0xA5A5.
3. bus_gnt toggling 1,0,1,0 during XFER -> bus_rd never asserted while gnt=0; still 384 in-order writes with no duplicates; done asserted.
4. Command with base 0 -> bus_req stays 0, no writes, mapped=0; done pulses 1 cycle after acceptance.
5. RST asserted after the 100th VRAM write -> no further writes; outputs at reset values; cmd_ready=1 after release; a fresh command completes correctly.
6. With LEM_VRAM_LOADER_REFRESH_EN, map 0x8000, then two frame_ticks while busy -> exactly one extra copy, starting on the cycle after DONE. Without the macro: frame_tick produces no bus_req.
